// File: rtl/alu_uart_sequencer.sv
// Sequencer between the UART and a combinational ALU: gathers operand A, operand B
// and opcode bytes, latches the 9-bit ALU result and returns it as two tx bytes.
module alu_uart_sequencer #(
   parameter int NB_DATA = 8,
   parameter int NB_OPS  = 6
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [NB_DATA-1:0] i_rx_data,
   input  logic               i_rx_done,
   input  logic [NB_DATA:0]   i_alu_res,
   input  logic               i_tx_done,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_OPS-1:0]  o_ops,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_done
);

   typedef enum logic [2:0] {
      WAIT_A,
      WAIT_B,
      WAIT_OP,
      EXEC,
      SEND_LO,
      WAIT_LO,
      SEND_HI,
      WAIT_HI
   } state_t;

   state_t               state_q;
   logic [NB_DATA-1:0]   data_a_q;
   logic [NB_DATA-1:0]   data_b_q;
   logic [NB_OPS-1:0]    ops_q;
   logic [NB_DATA:0]     res_q;
   logic [NB_DATA-1:0]   tx_data_q;
   logic                 tx_start_q;
   logic                 busy_q;
   logic                 done_q;

   // Strobes seen outside their waiting state fall through the case untouched,
   // so stray rx bytes and tx_done pulses are simply dropped.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= WAIT_A;
         data_a_q   <= '0;
         data_b_q   <= '0;
         ops_q      <= '0;
         res_q      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         done_q     <= 1'b0;
         unique case (state_q)
            WAIT_A: begin
               if (i_rx_done) begin
                  data_a_q <= i_rx_data;
                  state_q  <= WAIT_B;
               end
            end
            WAIT_B: begin
               if (i_rx_done) begin
                  data_b_q <= i_rx_data;
                  state_q  <= WAIT_OP;
               end
            end
            WAIT_OP: begin
               if (i_rx_done) begin
                  ops_q   <= i_rx_data[NB_OPS-1:0];
                  busy_q  <= 1'b1;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               // Low byte is registered straight from the ALU so tx_start is high in SEND_LO.
               res_q      <= i_alu_res;
               tx_data_q  <= i_alu_res[NB_DATA-1:0];
               tx_start_q <= 1'b1;
               state_q    <= SEND_LO;
            end
            SEND_LO: begin
               state_q <= WAIT_LO;
            end
            WAIT_LO: begin
               if (i_tx_done) begin
                  tx_data_q  <= NB_DATA'(res_q >> NB_DATA);
                  tx_start_q <= 1'b1;
                  state_q    <= SEND_HI;
               end
            end
            SEND_HI: begin
               state_q <= WAIT_HI;
            end
            WAIT_HI: begin
               if (i_tx_done) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= WAIT_A;
               end
            end
            default: begin
               state_q <= WAIT_A;
            end
         endcase
      end
   end

   assign o_data_a   = data_a_q;
   assign o_data_b   = data_b_q;
   assign o_ops      = ops_q;
   assign o_tx_data  = tx_data_q;
   assign o_tx_start = tx_start_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Directed bench for alu_uart_sequencer with a small reference ALU wired to its ports.
module tb_alu_uart_sequencer;

   localparam int NB_DATA = 8;
   localparam int NB_OPS  = 6;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NB_DATA-1:0] rx_data = '0;
   logic               rx_done = 1'b0;
   logic [NB_DATA:0]   alu_res;
   logic               tx_done = 1'b0;
   logic [NB_DATA-1:0] data_a, data_b, tx_data;
   logic [NB_OPS-1:0]  ops;
   logic               tx_start, busy, done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Reference ALU: add keeps carry, sub drops borrow, and/or have no carry.
   always_comb begin
      alu_res = '0;
      case (ops)
         6'h20: alu_res = {1'b0, data_a} + {1'b0, data_b};
         6'h22: alu_res = {1'b0, data_a - data_b};
         6'h24: alu_res = {1'b0, data_a & data_b};
         6'h25: alu_res = {1'b0, data_a | data_b};
         default: alu_res = '0;
      endcase
   end

   alu_uart_sequencer #(.NB_DATA(NB_DATA), .NB_OPS(NB_OPS)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_rx_data  (rx_data),
      .i_rx_done  (rx_done),
      .i_alu_res  (alu_res),
      .i_tx_done  (tx_done),
      .o_data_a   (data_a),
      .o_data_b   (data_b),
      .o_ops      (ops),
      .o_tx_data  (tx_data),
      .o_tx_start (tx_start),
      .o_busy     (busy),
      .o_done     (done)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".a"}, 16'(data_a), 16'h0);
      chk({tag, ".b"}, 16'(data_b), 16'h0);
      chk({tag, ".ops"}, 16'(ops), 16'h0);
      chk({tag, ".txd"}, 16'(tx_data), 16'h0);
      chk({tag, ".start"}, 16'(tx_start), 16'h0);
      chk({tag, ".busy"}, 16'(busy), 16'h0);
      chk({tag, ".done"}, 16'(done), 16'h0);
   endtask

   // Full transaction, driven and sampled on falling edges.
   // spur: tx_done pulse while in SEND_LO; inj: rx byte 0xAA during WAIT_LO;
   // rst_hi: reset asserted in WAIT_HI instead of completing.
   task automatic txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] op, input logic [7:0] lo, input logic [7:0] hi,
                      input bit spur, input bit inj, input bit rst_hi);
      logic [5:0] op6;
      op6 = op[5:0];
      @(negedge clk); rx_data = a;  rx_done = 1'b1;
      @(negedge clk); rx_data = b;
      chk({tag, ".a_loaded"}, 16'(data_a), 16'(a));
      @(negedge clk); rx_data = op;
      chk({tag, ".busy_pre"}, 16'(busy), 16'h0);
      @(negedge clk); rx_done = 1'b0;
      // EXEC cycle: first cycle after the opcode edge
      chk({tag, ".busy_exec"}, 16'(busy), 16'h1);
      chk({tag, ".start_exec"}, 16'(tx_start), 16'h0);
      chk({tag, ".a"}, 16'(data_a), 16'(a));
      chk({tag, ".b"}, 16'(data_b), 16'(b));
      chk({tag, ".ops"}, 16'(ops), 16'(op6));
      @(negedge clk);
      // SEND_LO cycle
      chk({tag, ".start_lo"}, 16'(tx_start), 16'h1);
      chk({tag, ".txd_lo"}, 16'(tx_data), 16'(lo));
      tx_done = spur;
      @(negedge clk);
      // WAIT_LO
      tx_done = 1'b0;
      chk({tag, ".start_wlo"}, 16'(tx_start), 16'h0);
      chk({tag, ".txd_wlo"}, 16'(tx_data), 16'(lo));
      rx_done = inj; rx_data = 8'hAA;
      @(negedge clk);
      // still WAIT_LO: any spurious/injected strobe must have had no effect
      rx_done = 1'b0;
      chk({tag, ".start_wlo2"}, 16'(tx_start), 16'h0);
      chk({tag, ".txd_wlo2"}, 16'(tx_data), 16'(lo));
      chk({tag, ".a_hold"}, 16'(data_a), 16'(a));
      chk({tag, ".b_hold"}, 16'(data_b), 16'(b));
      chk({tag, ".ops_hold"}, 16'(ops), 16'(op6));
      tx_done = 1'b1;
      @(negedge clk);
      // SEND_HI
      tx_done = 1'b0;
      chk({tag, ".start_hi"}, 16'(tx_start), 16'h1);
      chk({tag, ".txd_hi"}, 16'(tx_data), 16'(hi));
      @(negedge clk);
      // WAIT_HI
      chk({tag, ".start_whi"}, 16'(tx_start), 16'h0);
      chk({tag, ".txd_whi"}, 16'(tx_data), 16'(hi));
      chk({tag, ".busy_whi"}, 16'(busy), 16'h1);
      chk({tag, ".done_whi"}, 16'(done), 16'h0);
      if (rst_hi) begin
         #1 rst_n = 1'b0;
         #1 chk_all_zero({tag, ".async_rst"});
         @(negedge clk); rst_n = 1'b1;
         @(negedge clk);
         chk_all_zero({tag, ".post_rst"});
      end else begin
         tx_done = 1'b1;
         @(negedge clk);
         tx_done = 1'b0;
         chk({tag, ".done_pulse"}, 16'(done), 16'h1);
         chk({tag, ".busy_end"}, 16'(busy), 16'h0);
         @(negedge clk);
         chk({tag, ".done_once"}, 16'(done), 16'h0);
         chk({tag, ".start_idle"}, 16'(tx_start), 16'h0);
      end
   endtask

   initial begin
      #2 chk_all_zero("reset");
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk_all_zero("after_reset");

      txn("add",   8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0);
      txn("carry", 8'hFF, 8'h01, 8'h20, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
      txn("sub",   8'h03, 8'h05, 8'h22, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0);
      txn("and",   8'h0C, 8'h0A, 8'h24, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0);

      // Stray tx_done while idle must not disturb anything
      @(negedge clk); tx_done = 1'b1;
      @(negedge clk); tx_done = 1'b0;
      chk("idle_txdone.busy", 16'(busy), 16'h0);
      chk("idle_txdone.start", 16'(tx_start), 16'h0);
      chk("idle_txdone.done", 16'(done), 16'h0);
      chk("idle_txdone.a", 16'(data_a), 16'h0C);
      txn("spur",  8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0);

      txn("rst_mid", 8'h07, 8'h02, 8'h20, 8'h09, 8'h00, 1'b0, 1'b0, 1'b1);
      txn("or",    8'h01, 8'h01, 8'h25, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_uart_sequencer.md
Name: alu_uart_sequencer

Overview:
Control stage between the UART receiver/transmitter and the combinational ALU. It collects three received bytes in order: operand A, operand B, opcode. It drives them as registered values to the ALU and captures the 9-bit ALU result. It then returns the result to the UART transmitter as two bytes, using a start/done handshake.

Parameters:
NB_DATA, 8, width of operands, received bytes and transmitted bytes
NB_OPS, 6, width of the opcode driven to the ALU; taken from the low NB_OPS bits of the opcode byte

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst_n  in  1  asynchronous, active-low reset
i_rx_data  in  NB_DATA  byte from UART receiver
i_rx_done  in  1  one-cycle strobe; i_rx_data valid this cycle
i_alu_res  in  NB_DATA+1  ALU result {carry, res[NB_DATA-1:0]}
i_tx_done  in  1  one-cycle strobe from UART transmitter; current byte finished
o_data_a  out  NB_DATA  registered operand A to ALU
o_data_b  out  NB_DATA  registered operand B to ALU
o_ops  out  NB_OPS  registered opcode to ALU
o_tx_data  out  NB_DATA  byte to UART transmitter
o_tx_start  out  1  one-cycle request to transmit o_tx_data
o_busy  out  1  high from opcode capture until the second byte's i_tx_done
o_done  out  1  one-cycle pulse on completion of a full transaction

Behaviour:
- Reset (async, i_rst_n=0):
  - State returns to WAIT_A.
  - o_data_a, o_data_b, o_ops, o_tx_data and the internal result register go to 0.
  - o_tx_start, o_busy and o_done go to 0.
  - Reset at any point mid-transaction abandons it; no further tx_start is issued.
- FSM states and transitions:
  - WAIT_A: on i_rx_done, load o_data_a <= i_rx_data and go to WAIT_B.
  - WAIT_B: on i_rx_done, load o_data_b <= i_rx_data and go to WAIT_OP.
  - WAIT_OP: on i_rx_done, load o_ops <= i_rx_data[NB_OPS-1:0] and go to EXEC.
  - EXEC: stays one cycle. The ALU inputs are stable this cycle. Latch result <= i_alu_res, then go to SEND_LO.
  - SEND_LO: stays one cycle. o_tx_data = result[NB_DATA-1:0] and o_tx_start = 1. Go to WAIT_LO.
  - WAIT_LO: on i_tx_done go to SEND_HI.
  - SEND_HI: stays one cycle. o_tx_data = {(NB_DATA-1)'b0, result[NB_DATA]} and o_tx_start = 1. Go to WAIT_HI.
  - WAIT_HI: on i_tx_done, pulse o_done for one cycle and go to WAIT_A.
- Latency:
  - Clock edge k captures the opcode.
  - o_tx_start is high during the cycle after edge k+1, exactly one cycle wide.
  - o_busy rises with edge k and falls with the edge that leaves WAIT_HI.
- o_tx_data is registered and is held stable from SEND_x through the matching WAIT_x.
- o_data_a, o_data_b and o_ops hold their values until overwritten by the next transaction.
- No arithmetic is done in this block. The result is passed through unmodified as 9 bits, split into two bytes.
- Boundary conditions:
  - i_rx_done in EXEC, SEND_x or WAIT_x: byte dropped, no state change, no register change.
  - i_tx_done outside WAIT_LO/WAIT_HI: ignored.
  - i_tx_done in the same cycle as SEND_x: ignored. Only a strobe seen while in WAIT_x advances the FSM.
  - i_rx_done and i_tx_done in the same cycle while in WAIT_x: tx_done is processed and the rx byte is dropped.
  - Back-to-back transactions: after the edge leaving WAIT_HI, an i_rx_done in the very next cycle loads A.
  - An i_rx_done in the same cycle as the WAIT_HI exit strobe is dropped.
  - Stuck high inputs: i_rx_done held high for multiple cycles is treated as one strobe per cycle.

Test Plan:
- Add: bench wires the real ALU. Rx bytes 0x05, 0x03, 0x20 -> tx bytes 0x08 then 0x00. One o_done pulse. o_data_a=0x05, o_data_b=0x03, o_ops=0x20.
- Carry: rx 0xFF, 0x01, 0x20 -> ALU {1, 0x00} -> tx bytes 0x00 then 0x01.
- Sub and latency: rx 0x03, 0x05, 0x22 -> tx 0xFE then 0x00. Check o_tx_start is high exactly one cycle, in the 2nd cycle after the opcode edge. Check o_busy timing.
- Drop while busy: after the opcode, inject rx 0xAA during WAIT_LO -> no change to o_data_a/o_data_b/o_ops. Next transaction 0x0C, 0x0A, 0x24 -> tx 0x08, 0x00.
- Spurious handshake: pulse i_tx_done in WAIT_A and in SEND_LO -> no state change. Only the WAIT_LO strobe advances the FSM.
- Reset mid-operation: assert i_rst_n=0 during WAIT_HI -> all outputs 0 immediately (async). After release, a fresh 0x01, 0x01, 0x25 -> tx 0x01, 0x00.
